// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage.
// Optional build macro IF_MISALIGN_CHK_EN is off unless defined on the command line.
package if_fetch_stage_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] IF_PC_STEP  = 32'd4;

endpackage

// File: rtl/if_replay_buf.sv
// One-entry replay buffer: holds the fetch response that arrived while IF was held.
module if_replay_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] cap_inst,
  input  logic [31:0] cap_pc,
  output logic        buf_vld,
  output logic [31:0] buf_inst,
  output logic [31:0] buf_pc
);

  // clear wins: a redirect must discard an entry even while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_inst <= '0;
      buf_pc   <= '0;
    end else if (clear) begin
      buf_vld <= 1'b0;
    end else if (capture) begin
      buf_vld  <= 1'b1;
      buf_inst <= cap_inst;
      buf_pc   <= cap_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, 1-cycle-latency imem issue, replay on hold, squash on redirect.
// Build macro IF_MISALIGN_CHK_EN adds the sticky if_misalign_err output and word-aligns jump targets.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INST = IF_NOP_INST,
  parameter logic [31:0] PC_STEP  = IF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_IF,
  input  logic        nop_IF,
  input  logic        jmp_vld_IF,
  input  logic [31:0] jmp_addr_IF,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc,
  output logic        IF_inst_vld
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        if_misalign_err
`endif
);

  logic [31:0] pc;
  logic        rsp_vld;
  logic [31:0] rsp_pc;
  logic        redir;
  logic [31:0] last_pc;
  logic [31:0] jmp_tgt;

  logic        buf_vld;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        buf_capture;
  logic        buf_clear;

  logic [31:0] sel_inst;
  logic [31:0] sel_pc;

`ifdef IF_MISALIGN_CHK_EN
  assign jmp_tgt = {jmp_addr_IF[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_misalign_err <= 1'b0;
    end else if (jmp_vld_IF && (jmp_addr_IF[1:0] != 2'b00)) begin
      if_misalign_err <= 1'b1;
    end
  end
`else
  assign jmp_tgt = jmp_addr_IF;
`endif

  assign imem_en   = ~rst & ~hold_IF & ~jmp_vld_IF;
  assign imem_addr = pc;

  // Park a response arriving during a hold; release it on the first unheld cycle.
  assign buf_capture = hold_IF & ~jmp_vld_IF & rsp_vld & ~buf_vld;
  assign buf_clear   = jmp_vld_IF | ~hold_IF;

  if_replay_buf u_replay_buf (
    .clk      (clk),
    .rst      (rst),
    .capture  (buf_capture),
    .clear    (buf_clear),
    .cap_inst (imem_rdata),
    .cap_pc   (rsp_pc),
    .buf_vld  (buf_vld),
    .buf_inst (buf_inst),
    .buf_pc   (buf_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      rsp_vld <= 1'b0;
      rsp_pc  <= RESET_PC;
      redir   <= 1'b0;
      last_pc <= RESET_PC;
    end else begin
      redir   <= jmp_vld_IF;
      last_pc <= IF_pc;
      if (jmp_vld_IF) begin
        pc      <= jmp_tgt;
        rsp_vld <= 1'b0;
      end else if (imem_en) begin
        pc      <= pc + PC_STEP;
        rsp_vld <= 1'b1;
        rsp_pc  <= pc;
      end else begin
        rsp_vld <= 1'b0;
      end
    end
  end

  // Buffered entry is older than any live response, so it is presented first.
  always_comb begin
    sel_inst = NOP_INST;
    sel_pc   = last_pc;
    if (buf_vld) begin
      sel_inst = buf_inst;
      sel_pc   = buf_pc;
    end else if (rsp_vld) begin
      sel_inst = imem_rdata;
      sel_pc   = rsp_pc;
    end
    IF_inst_vld = (buf_vld | rsp_vld) & ~nop_IF & ~jmp_vld_IF & ~redir;
    IF_inst     = IF_inst_vld ? sel_inst : NOP_INST;
    IF_pc       = sel_pc;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus hand sequences for misalign and async reset.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        hold_IF;
  logic        nop_IF;
  logic        jmp_vld_IF;
  logic [31:0] jmp_addr_IF;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
  logic        IF_inst_vld;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .hold_IF     (hold_IF),
    .nop_IF      (nop_IF),
    .jmp_vld_IF  (jmp_vld_IF),
    .jmp_addr_IF (jmp_addr_IF),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .IF_inst     (IF_inst),
    .IF_pc       (IF_pc),
    .IF_inst_vld (IF_inst_vld)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .if_misalign_err (misalign_err)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word at address a reads as a + 0x1000_0000, one cycle late.
  function automatic logic [31:0] ival(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= ival(imem_addr);
  end

  typedef struct {
    logic        hold;
    logic        nop;
    logic        jmp;
    logic [31:0] ja;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic h, input logic n, input logic j, input logic [31:0] ja,
                              input logic e, input logic [31:0] ad, input logic v,
                              input logic [31:0] in, input logic [31:0] p);
    vec_t r;
    r.hold = h; r.nop = n; r.jmp = j; r.ja = ja;
    r.en = e; r.addr = ad; r.vld = v; r.inst = in; r.pc = p;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic n, input logic j, input logic [31:0] ja);
    hold_IF     = h;
    nop_IF      = n;
    jmp_vld_IF  = j;
    jmp_addr_IF = ja;
  endtask

  logic [31:0] mis_tgt;

  initial begin
    // sequential fetch, hold, load-use, redirect, jump-in-hold, back-to-back jumps, nop, PC wrap
    vecs[0]  = mk(0,0,0,0,            1, 32'h0,        0, NOP,                32'h0);
    vecs[1]  = mk(0,0,0,0,            1, 32'h4,        1, ival(32'h0),        32'h0);
    vecs[2]  = mk(0,0,0,0,            1, 32'h8,        1, ival(32'h4),        32'h4);
    vecs[3]  = mk(1,0,0,0,            0, 32'hC,        1, ival(32'h8),        32'h8);
    vecs[4]  = mk(1,0,0,0,            0, 32'hC,        1, ival(32'h8),        32'h8);
    vecs[5]  = mk(1,0,0,0,            0, 32'hC,        1, ival(32'h8),        32'h8);
    vecs[6]  = mk(0,0,0,0,            1, 32'hC,        1, ival(32'h8),        32'h8);
    vecs[7]  = mk(0,0,0,0,            1, 32'h10,       1, ival(32'hC),        32'hC);
    vecs[8]  = mk(1,1,0,0,            0, 32'h14,       0, NOP,                32'h10);
    vecs[9]  = mk(0,0,0,0,            1, 32'h14,       1, ival(32'h10),       32'h10);
    vecs[10] = mk(0,0,0,0,            1, 32'h18,       1, ival(32'h14),       32'h14);
    vecs[11] = mk(0,0,1,32'h100,      0, 32'h1C,       0, NOP,                32'h18);
    vecs[12] = mk(0,0,0,0,            1, 32'h100,      0, NOP,                32'h18);
    vecs[13] = mk(0,0,0,0,            1, 32'h104,      1, ival(32'h100),      32'h100);
    vecs[14] = mk(0,0,0,0,            1, 32'h108,      1, ival(32'h104),      32'h104);
    vecs[15] = mk(1,0,0,0,            0, 32'h10C,      1, ival(32'h108),      32'h108);
    vecs[16] = mk(1,0,1,32'h200,      0, 32'h10C,      0, NOP,                32'h108);
    vecs[17] = mk(0,0,0,0,            1, 32'h200,      0, NOP,                32'h108);
    vecs[18] = mk(0,0,0,0,            1, 32'h204,      1, ival(32'h200),      32'h200);
    vecs[19] = mk(0,0,1,32'h300,      0, 32'h208,      0, NOP,                32'h204);
    vecs[20] = mk(0,0,1,32'h400,      0, 32'h300,      0, NOP,                32'h204);
    vecs[21] = mk(0,0,0,0,            1, 32'h400,      0, NOP,                32'h204);
    vecs[22] = mk(0,0,0,0,            1, 32'h404,      1, ival(32'h400),      32'h400);
    vecs[23] = mk(0,1,0,0,            1, 32'h408,      0, NOP,                32'h404);
    vecs[24] = mk(0,0,0,0,            1, 32'h40C,      1, ival(32'h408),      32'h408);
    vecs[25] = mk(0,0,1,32'hFFFF_FFF8,0, 32'h410,      0, NOP,                32'h40C);
    vecs[26] = mk(0,0,0,0,            1, 32'hFFFF_FFF8,0, NOP,                32'h40C);
    vecs[27] = mk(0,0,0,0,            1, 32'hFFFF_FFFC,1, ival(32'hFFFF_FFF8),32'hFFFF_FFF8);
    vecs[28] = mk(0,0,0,0,            1, 32'h0,        1, ival(32'hFFFF_FFFC),32'hFFFF_FFFC);
    vecs[29] = mk(0,0,0,0,            1, 32'h4,        1, ival(32'h0),        32'h0);

    rst        = 1'b1;
    imem_rdata = 32'h0;
    drive(0, 0, 0, 32'h0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_en",   32'(imem_en),     32'h0);
    chk("rst_vld",  32'(IF_inst_vld), 32'h0);
    chk("rst_inst", IF_inst,          NOP);
    chk("rst_pc",   IF_pc,            32'h0);
`ifdef IF_MISALIGN_CHK_EN
    chk("rst_err",  32'(misalign_err), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].hold, vecs[i].nop, vecs[i].jmp, vecs[i].ja);
      #1;
      chk($sformatf("r%0d_en",   i), 32'(imem_en),     32'(vecs[i].en));
      chk($sformatf("r%0d_addr", i), imem_addr,        vecs[i].addr);
      chk($sformatf("r%0d_vld",  i), 32'(IF_inst_vld), 32'(vecs[i].vld));
      chk($sformatf("r%0d_inst", i), IF_inst,          vecs[i].inst);
      chk($sformatf("r%0d_pc",   i), IF_pc,            vecs[i].pc);
      @(negedge clk);
    end

    // misaligned jump target
`ifdef IF_MISALIGN_CHK_EN
    mis_tgt = 32'h500;
    chk("mis_err_pre", 32'(misalign_err), 32'h0);
`else
    mis_tgt = 32'h502;
`endif
    drive(0, 0, 1, 32'h502);
    #1;
    chk("mis_j_vld", 32'(IF_inst_vld), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0);
    #1;
    chk("mis_j1_en",   32'(imem_en),     32'h1);
    chk("mis_j1_addr", imem_addr,        mis_tgt);
    chk("mis_j1_vld",  32'(IF_inst_vld), 32'h0);
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_j1_err",  32'(misalign_err), 32'h1);
`endif
    @(negedge clk);
    #1;
    chk("mis_j2_vld",  32'(IF_inst_vld), 32'h1);
    chk("mis_j2_pc",   IF_pc,            mis_tgt);
    chk("mis_j2_inst", IF_inst,          ival(mis_tgt));
`ifdef IF_MISALIGN_CHK_EN
    chk("mis_j2_err",  32'(misalign_err), 32'h1);
`endif
    @(negedge clk);

    // async reset in the middle of a hold with a buffered entry
    drive(1, 0, 0, 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en",   32'(imem_en),     32'h0);
    chk("arst_vld",  32'(IF_inst_vld), 32'h0);
    chk("arst_inst", IF_inst,          NOP);
    chk("arst_pc",   IF_pc,            32'h0);
    chk("arst_addr", imem_addr,        32'h0);
`ifdef IF_MISALIGN_CHK_EN
    chk("arst_err",  32'(misalign_err), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0);
    #1;
    chk("rel_en",   32'(imem_en),     32'h1);
    chk("rel_addr", imem_addr,        32'h0);
    chk("rel_vld",  32'(IF_inst_vld), 32'h0);
    @(negedge clk);
    #1;
    chk("rel1_vld",  32'(IF_inst_vld), 32'h1);
    chk("rel1_pc",   IF_pc,            32'h0);
    chk("rel1_inst", IF_inst,          ival(32'h0));
    chk("rel1_addr", imem_addr,        32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
